// File: rtl/ballot_input_ctrl.sv
// Ballot booth front end: sync + debounce of buttons/officer switches, one vote per arm.
// Latency: raw button edge to vote_pulse is DEBOUNCE_CYCLES+4 clk edges.
// Backpressure: none; vote_pulse/vote_valid is a single-cycle push to the tally stage.
module ballot_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       s1,
  input  logic       s2,
  output logic [3:0] vote_pulse,
  output logic       vote_valid,
  output logic       armed,
  output logic       err_multi,
  output logic       closed
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] CAST    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] CLOSED  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit order: b1..b4, s1, s2
  logic [5:0]            raw;
  logic [5:0]            sync1;
  logic [5:0]            sync2;
  logic [5:0]            deb;
  logic [4:0]            deb_q;
  logic [4:0]            rise_r;
  logic [5:0][CNT_W-1:0] cnt;

  logic [2:0] state;
  logic [2:0] state_d;
  logic [3:0] vote_d;
  logic [3:0] btn;
  logic [3:0] btn_rise;

  assign raw = {s2, s1, b4, b3, b2, b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_q  <= '0;
      rise_r <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      deb_q  <= deb[4:0];
      rise_r <= deb[4:0] & ~deb_q;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  function automatic logic is_onehot(input logic [3:0] x);
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
  endfunction

  assign btn      = deb[3:0];
  assign btn_rise = rise_r[3:0];

  // The close switch overrides every state; a vote is only taken when the
  // rising button is the sole button held.
  always_comb begin
    state_d = state;
    vote_d  = '0;
    if (deb[5]) begin
      state_d = CLOSED;
    end else begin
      case (state)
        IDLE:    if (rise_r[4] && (btn == 4'd0)) state_d = ARMED;
        ARMED: begin
          if (is_onehot(btn_rise) && (btn == btn_rise)) begin
            state_d = CAST;
            vote_d  = btn_rise;
          end
        end
        CAST:    state_d = RELEASE;
        RELEASE: if (btn == 4'd0) state_d = IDLE;
        CLOSED:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vote_pulse <= '0;
      vote_valid <= 1'b0;
    end else begin
      state      <= state_d;
      vote_pulse <= vote_d;
      vote_valid <= (vote_d != 4'd0);
    end
  end

  assign armed     = (state == ARMED);
  assign closed    = (state == CLOSED);
  assign err_multi = armed && (btn != 4'd0) && !is_onehot(btn);

endmodule

// File: tb/tb_ballot_input_ctrl.sv
// Bench for ballot_input_ctrl: directed scenarios plus random button/switch activity
// compared cycle by cycle against a behavioural model of the booth rules.
module tb_ballot_input_ctrl;

  localparam int D = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAST = 2, M_RELEASE = 3, M_CLOSED = 4;

  logic       clk, rst;
  logic       b1, b2, b3, b4, s1, s2;
  logic [3:0] vote_pulse;
  logic       vote_valid, armed, err_multi, closed;

  int checks = 0;
  int failures = 0;

  ballot_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .s1(s1), .s2(s2),
    .vote_pulse(vote_pulse), .vote_valid(vote_valid),
    .armed(armed), .err_multi(err_multi), .closed(closed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw sample history, run length of disagreeing samples, and booth state.
  logic [5:0] m_raw1, m_raw2;
  logic [5:0] m_deb, m_deb_p1, m_deb_p2;
  int         m_run [6];
  int         m_st;
  logic [3:0] m_vote;

  task automatic model_reset();
    m_raw1 = '0; m_raw2 = '0;
    m_deb = '0; m_deb_p1 = '0; m_deb_p2 = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_st = M_IDLE;
    m_vote = '0;
  endtask

  task automatic model_step(input logic [5:0] r);
    logic [5:0] deb_new, rises;
    logic [3:0] held, brise;
    deb_new = m_deb;
    for (int i = 0; i < 6; i++) begin
      if (m_raw2[i] != m_deb[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          deb_new[i] = m_raw2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    rises = m_deb_p1 & ~m_deb_p2;
    brise = rises[3:0];
    held  = m_deb[3:0];
    m_vote = '0;
    if (m_deb[5]) m_st = M_CLOSED;
    else if (m_st == M_IDLE && rises[4] && held == 0) m_st = M_ARMED;
    else if (m_st == M_ARMED && $countones(brise) == 1 && held == brise) begin
      m_st = M_CAST;
      m_vote = brise;
    end
    else if (m_st == M_CAST) m_st = M_RELEASE;
    else if (m_st == M_RELEASE && held == 0) m_st = M_IDLE;
    else if (m_st == M_CLOSED) m_st = M_IDLE;
    m_deb_p2 = m_deb_p1;
    m_deb_p1 = m_deb;
    m_deb    = deb_new;
    m_raw2   = m_raw1;
    m_raw1   = r;
  endtask

  function automatic logic [7:0] obs();
    return {vote_pulse, vote_valid, armed, err_multi, closed};
  endfunction

  function automatic logic [7:0] mexp();
    logic [3:0] h;
    h = m_deb[3:0];
    return {m_vote, (m_vote != 0), (m_st == M_ARMED),
            (m_st == M_ARMED) && ($countones(h) > 1), (m_st == M_CLOSED)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step({s2, s1, b4, b3, b2, b1});
    @(negedge clk);
  endtask

  task automatic arm();
    s1 = 1'b1;
    repeat (10) begin
      cyc();
      checks++;
      if (obs() !== mexp()) begin failures++; $display("FAIL arm_model got=%b exp=%b", obs(), mexp()); end
    end
    s1 = 1'b0;
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL arm_lamp got=%b exp=1", armed); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL reset_outputs got=%b exp=00000000", obs()); end
    rst = 1'b0;
    repeat (3) cyc();
    checks++;
    if (obs() !== 8'h00) begin failures++; $display("FAIL post_reset got=%b exp=00000000", obs()); end
    b1 = 1'b1;
    repeat (6) cyc();
    b1 = 1'b0;
    repeat (15) begin
      cyc();
      checks++;
      if (vote_pulse !== 4'd0 || obs() !== mexp()) begin
        failures++; $display("FAIL idle_press got=%b exp=%b", obs(), mexp());
      end
    end
  endtask

  task automatic test_vote();
    arm();
    b2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 10) b2 = 1'b0;
      checks++;
      if (vote_pulse !== ((k == 8) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL vote_latency edge=%0d got=%b exp=%b", k, vote_pulse, (k == 8) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (obs() !== mexp()) begin failures++; $display("FAIL vote_model got=%b exp=%b", obs(), mexp()); end
    end
    repeat (10) cyc();
    checks++;
    if (armed !== 1'b0) begin failures++; $display("FAIL disarm_after_vote got=%b exp=0", armed); end
    b2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 10) b2 = 1'b0;
      checks++;
      if (vote_pulse !== 4'd0) begin failures++; $display("FAIL second_press got=%b exp=0000", vote_pulse); end
    end
  endtask

  task automatic test_glitch();
    bit got;
    arm();
    b3 = 1'b1;
    repeat (2) cyc();
    b3 = 1'b0;
    repeat (10) begin
      cyc();
      checks++;
      if (vote_pulse !== 4'd0 || armed !== 1'b1) begin
        failures++; $display("FAIL glitch got_pulse=%b armed=%b exp_pulse=0000 armed=1", vote_pulse, armed);
      end
    end
    b3 = 1'b1;
    got = 0;
    for (int k = 0; k < 15 && !got; k++) begin
      cyc();
      if (vote_pulse == 4'b0100) got = 1;
      checks++;
      if (obs() !== mexp()) begin failures++; $display("FAIL glitch_model got=%b exp=%b", obs(), mexp()); end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL glitch_then_hold got=no_pulse exp=0100"); end
    b3 = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_multi();
    bit got;
    arm();
    b1 = 1'b1; b4 = 1'b1;
    repeat (10) begin
      cyc();
      checks++;
      if (vote_pulse !== 4'd0 || obs() !== mexp()) begin
        failures++; $display("FAIL multi_model got=%b exp=%b", obs(), mexp());
      end
    end
    checks++;
    if (err_multi !== 1'b1 || armed !== 1'b1) begin
      failures++; $display("FAIL multi_err got_err=%b armed=%b exp_err=1 armed=1", err_multi, armed);
    end
    b1 = 1'b0; b4 = 1'b0;
    repeat (8) cyc();
    checks++;
    if (err_multi !== 1'b0 || armed !== 1'b1) begin
      failures++; $display("FAIL multi_release got_err=%b armed=%b exp_err=0 armed=1", err_multi, armed);
    end
    b4 = 1'b1;
    got = 0;
    for (int k = 0; k < 15 && !got; k++) begin
      cyc();
      if (vote_pulse == 4'b1000) got = 1;
      checks++;
      if (obs() !== mexp()) begin failures++; $display("FAIL multi_vote_model got=%b exp=%b", obs(), mexp()); end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL multi_then_b4 got=no_pulse exp=1000"); end
    b4 = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_close();
    arm();
    s2 = 1'b1;
    repeat (10) cyc();
    checks++;
    if (closed !== 1'b1 || armed !== 1'b0) begin
      failures++; $display("FAIL close got_closed=%b armed=%b exp_closed=1 armed=0", closed, armed);
    end
    b1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 10) b1 = 1'b0;
      checks++;
      if (vote_pulse !== 4'd0 || obs() !== mexp()) begin
        failures++; $display("FAIL closed_press got=%b exp=%b", obs(), mexp());
      end
    end
    s2 = 1'b0;
    repeat (10) cyc();
    checks++;
    if (closed !== 1'b0 || armed !== 1'b0) begin
      failures++; $display("FAIL reopen got_closed=%b armed=%b exp_closed=0 armed=0", closed, armed);
    end
    arm();
  endtask

  task automatic test_reset_in_cast();
    bit hit;
    b2 = 1'b1;
    hit = 0;
    for (int k = 0; k < 15 && !hit; k++) begin
      cyc();
      if (m_vote != 0) hit = 1;
    end
    checks++;
    if (!hit || vote_pulse !== 4'b0010) begin
      failures++; $display("FAIL cast_reached got=%b exp=0010", vote_pulse);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (vote_pulse !== 4'd0 || vote_valid !== 1'b0) begin
      failures++; $display("FAIL reset_in_cast got=%b/%b exp=0000/0", vote_pulse, vote_valid);
    end
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (k == 10) b2 = 1'b0;
      checks++;
      if (vote_pulse !== 4'd0 || armed !== 1'b0 || obs() !== mexp()) begin
        failures++; $display("FAIL after_reset got=%b exp=%b", obs(), mexp());
      end
    end
  endtask

  task automatic test_random();
    int votes;
    votes = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) b1 = ~b1;
      if ($urandom_range(0, 9) == 0) b2 = ~b2;
      if ($urandom_range(0, 9) == 0) b3 = ~b3;
      if ($urandom_range(0, 9) == 0) b4 = ~b4;
      if ($urandom_range(0, 14) == 0) s1 = ~s1;
      if ($urandom_range(0, 79) == 0) s2 = ~s2;
      cyc();
      if (m_vote != 0) votes++;
      checks++;
      if (obs() !== mexp()) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", k, obs(), mexp());
      end
    end
    $display("random phase: %0d votes modelled", votes);
  endtask

  initial begin
    rst = 1'b1;
    {b1, b2, b3, b4, s1, s2} = '0;
    model_reset();
    test_reset();
    test_vote();
    test_glitch();
    test_multi();
    test_close();
    test_reset_in_cast();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
